// File: rtl/fetch_pkg.sv
// Shared definitions for the fetch-side decoupling queue.
// Holds the queue sizing constants and the packet layout carried from
// fetch/branch-prediction to decode.
package fetch_pkg;

    localparam int FQ_DEPTH        = 8;
    localparam int FQ_PTR_W        = 3;
    localparam int BP_META_W       = 14;
    // Two slots of headroom cover the fetches already in flight when stall rises.
    localparam int FQ_STALL_THRESH = FQ_DEPTH - 2;

    typedef struct packed {
        logic [31:0]          pc;
        logic [31:0]          inst;
        logic                 p_dir;
        logic [BP_META_W-1:0] meta;
    } fq_entry_t;

endpackage

// File: rtl/fq_storage.sv
// Packet register file for fetch_queue: DEPTH entries, one synchronous
// write port and one asynchronous read port (shaped for MLAB mapping).
// Ports:
//   clk      in   clock
//   we_i     in   write enable
//   waddr_i  in   write slot
//   wdata_i  in   packet to store
//   raddr_i  in   read slot
//   rdata_o  out  packet in the read slot (combinational)
module fq_storage
    import fetch_pkg::*;
#(
    parameter int DEPTH = FQ_DEPTH,
    parameter int PTR_W = FQ_PTR_W
) (
    input  logic             clk,
    input  logic             we_i,
    input  logic [PTR_W-1:0] waddr_i,
    input  fq_entry_t        wdata_i,
    input  logic [PTR_W-1:0] raddr_i,
    output fq_entry_t        rdata_o
);

    fq_entry_t mem_q [DEPTH];

    // NOTE: the array has no reset; validity is tracked by the pointers and
    // counter, and leaving it unreset lets it map onto distributed RAM.
    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/fetch_queue.sv
// Decoupling FIFO between fetch/branch-prediction and decode.
// Show-ahead head, fetch stall on high occupancy, full drop on redirect,
// sticky overflow flag.
// Ports:
//   clk, reset                 clock, synchronous active-high reset
//   enq_valid/pc/inst/p_dir/meta  packet from fetch
//   flush                      fetch redirect: discard all entries
//   deq_ready                  decode takes the head this cycle
//   deq_valid/pc/inst/p_dir/meta  head packet (combinational from storage)
//   fq_stall                   stall request to fetch
//   fq_count                   occupancy 0..DEPTH
//   fq_overflow                sticky: push attempted while full with no pop
module fetch_queue
    import fetch_pkg::*;
#(
    parameter int DEPTH        = FQ_DEPTH,
    parameter int PTR_W        = FQ_PTR_W,
    parameter int META_W       = BP_META_W,
    parameter int STALL_THRESH = FQ_STALL_THRESH
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              enq_valid,
    input  logic [31:0]       enq_pc,
    input  logic [31:0]       enq_inst,
    input  logic              enq_p_dir,
    input  logic [META_W-1:0] enq_meta,
    input  logic              flush,
    input  logic              deq_ready,
    output logic              deq_valid,
    output logic [31:0]       deq_pc,
    output logic [31:0]       deq_inst,
    output logic              deq_p_dir,
    output logic [META_W-1:0] deq_meta,
    output logic              fq_stall,
    output logic [PTR_W:0]    fq_count,
    output logic              fq_overflow
);

    localparam logic [PTR_W:0] FULL_CNT  = (PTR_W+1)'(DEPTH);
    localparam logic [PTR_W:0] STALL_CNT = (PTR_W+1)'(STALL_THRESH);

    logic [PTR_W-1:0] head_q, head_d;
    logic [PTR_W-1:0] tail_q, tail_d;
    logic [PTR_W:0]   count_q, count_d;
    logic             overflow_q, overflow_d;

    logic      full;
    logic      deq_fire;
    logic      enq_fire;
    logic      wr_en;
    fq_entry_t wr_entry;
    fq_entry_t rd_entry;

    assign full      = (count_q == FULL_CNT);
    assign deq_valid = (count_q != '0);
    assign deq_fire  = deq_valid & deq_ready;
    // A same-cycle pop frees the slot, so a full queue can still accept.
    assign enq_fire  = enq_valid & (~full | deq_fire);
    // Flush drops the packet presented with it.
    assign wr_en     = enq_fire & ~flush;

    assign wr_entry.pc    = enq_pc;
    assign wr_entry.inst  = enq_inst;
    assign wr_entry.p_dir = enq_p_dir;
    assign wr_entry.meta  = enq_meta;

    fq_storage #(
        .DEPTH (DEPTH),
        .PTR_W (PTR_W)
    ) u_storage (
        .clk     (clk),
        .we_i    (wr_en),
        .waddr_i (tail_q),
        .wdata_i (wr_entry),
        .raddr_i (head_q),
        .rdata_o (rd_entry)
    );

    // NOTE: every next-state signal gets its hold value first so no path
    // through this block can infer a latch.
    always_comb begin
        head_d     = head_q;
        tail_d     = tail_q;
        count_d    = count_q;
        overflow_d = overflow_q;
        if (flush) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end else begin
            if (enq_fire) tail_d = tail_q + 1'b1;
            if (deq_fire) head_d = head_q + 1'b1;
            count_d = count_q + {{PTR_W{1'b0}}, enq_fire}
                              - {{PTR_W{1'b0}}, deq_fire};
            if (enq_valid && !enq_fire) overflow_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            head_q     <= '0;
            tail_q     <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            head_q     <= head_d;
            tail_q     <= tail_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
        end
    end

    assign deq_pc      = rd_entry.pc;
    assign deq_inst    = rd_entry.inst;
    assign deq_p_dir   = rd_entry.p_dir;
    assign deq_meta    = rd_entry.meta;
    assign fq_count    = count_q;
    assign fq_stall    = (count_q >= STALL_CNT);
    assign fq_overflow = overflow_q;

endmodule

// File: tb/tb_fetch_queue.sv
// Self-checking bench for fetch_queue: directed scenarios with literal
// expectations, then randomized traffic compared every cycle against a
// queue-based reference model.
module tb_fetch_queue;

    localparam int DEPTH = 8;

    logic        clk = 1'b0;
    logic        reset;
    logic        enq_valid;
    logic [31:0] enq_pc;
    logic [31:0] enq_inst;
    logic        enq_p_dir;
    logic [13:0] enq_meta;
    logic        flush;
    logic        deq_ready;
    logic        deq_valid;
    logic [31:0] deq_pc;
    logic [31:0] deq_inst;
    logic        deq_p_dir;
    logic [13:0] deq_meta;
    logic        fq_stall;
    logic [3:0]  fq_count;
    logic        fq_overflow;

    fetch_queue dut (
        .clk         (clk),
        .reset       (reset),
        .enq_valid   (enq_valid),
        .enq_pc      (enq_pc),
        .enq_inst    (enq_inst),
        .enq_p_dir   (enq_p_dir),
        .enq_meta    (enq_meta),
        .flush       (flush),
        .deq_ready   (deq_ready),
        .deq_valid   (deq_valid),
        .deq_pc      (deq_pc),
        .deq_inst    (deq_inst),
        .deq_p_dir   (deq_p_dir),
        .deq_meta    (deq_meta),
        .fq_stall    (fq_stall),
        .fq_count    (fq_count),
        .fq_overflow (fq_overflow)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    bit chk_en  = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: an ordered list of packets plus the sticky flag.
    typedef struct {
        logic [31:0] pc;
        logic [31:0] inst;
        logic        p_dir;
        logic [13:0] meta;
    } pkt_t;

    pkt_t m_q[$];
    bit   m_ovf = 1'b0;

    initial begin
        forever begin
            @(posedge clk);
            if (reset === 1'b1) begin
                m_q.delete();
                m_ovf = 1'b0;
            end else if (flush === 1'b1) begin
                m_q.delete();
            end else begin
                bit   pop;
                bit   push;
                pkt_t p;
                pop  = (m_q.size() > 0) && (deq_ready === 1'b1);
                push = (enq_valid === 1'b1) && ((m_q.size() < DEPTH) || pop);
                if ((enq_valid === 1'b1) && !push) m_ovf = 1'b1;
                if (pop) void'(m_q.pop_front());
                if (push) begin
                    p.pc = enq_pc; p.inst = enq_inst; p.p_dir = enq_p_dir; p.meta = enq_meta;
                    m_q.push_back(p);
                end
            end
        end
    end

    // Per-cycle comparison, away from the active edge.
    initial begin
        forever begin
            @(negedge clk);
            if (chk_en) begin
                check("cmp_valid",    deq_valid,   m_q.size() != 0);
                check("cmp_count",    fq_count,    m_q.size());
                check("cmp_stall",    fq_stall,    m_q.size() >= DEPTH - 2);
                check("cmp_overflow", fq_overflow, m_ovf);
                check("cmp_count_le_depth", fq_count <= DEPTH, 1'b1);
                if (m_q.size() != 0) begin
                    check("cmp_pc",    deq_pc,    m_q[0].pc);
                    check("cmp_inst",  deq_inst,  m_q[0].inst);
                    check("cmp_p_dir", deq_p_dir, m_q[0].p_dir);
                    check("cmp_meta",  deq_meta,  m_q[0].meta);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic step(input logic v, input logic [31:0] pc, input logic [31:0] inst,
                        input logic pd, input logic [13:0] meta,
                        input logic rdy, input logic fl, input logic rst);
        enq_valid = v;  enq_pc = pc; enq_inst = inst; enq_p_dir = pd; enq_meta = meta;
        deq_ready = rdy; flush = fl; reset = rst;
        tick();
    endtask

    task automatic drive(input logic v, input logic [31:0] pc, input logic rdy, input logic fl);
        step(v, pc, pc ^ 32'hA5A5_0000, pc[2], pc[15:2], rdy, fl, 1'b0);
    endtask

    task automatic do_reset();
        step(1'b0, '0, '0, 1'b0, '0, 1'b0, 1'b0, 1'b1);
    endtask

    initial begin
        // 1. reset and in-order delivery
        step(1'b0, '0, '0, 1'b0, '0, 1'b0, 1'b0, 1'b1);
        chk_en = 1'b1;
        do_reset();
        check("rst_valid", deq_valid, 1'b0);
        check("rst_count", fq_count, 4'd0);
        check("rst_stall", fq_stall, 1'b0);
        check("rst_overflow", fq_overflow, 1'b0);
        drive(1'b1, 32'h0, 1'b0, 1'b0);
        drive(1'b1, 32'h4, 1'b0, 1'b0);
        drive(1'b1, 32'h8, 1'b0, 1'b0);
        check("t1_count3", fq_count, 4'd3);
        check("t1_head0", deq_pc, 32'h0);
        drive(1'b0, '0, 1'b1, 1'b0);
        check("t1_head4", deq_pc, 32'h4);
        drive(1'b0, '0, 1'b1, 1'b0);
        check("t1_head8", deq_pc, 32'h8);
        drive(1'b0, '0, 1'b1, 1'b0);
        check("t1_empty", deq_valid, 1'b0);

        // 2. fill, stall threshold, overflow
        for (int k = 1; k <= 8; k++) begin
            drive(1'b1, 32'h40 + 32'(4 * k), 1'b0, 1'b0);
            check("t2_stall", fq_stall, k >= 6);
        end
        check("t2_full", fq_count, 4'd8);
        drive(1'b1, 32'h99, 1'b0, 1'b0);
        check("t2_overflow", fq_overflow, 1'b1);
        check("t2_count8", fq_count, 4'd8);
        check("t2_head", deq_pc, 32'h44);
        do_reset();
        check("t2_ovf_cleared", fq_overflow, 1'b0);

        // 3. push+pop while full, pointer wrap
        for (int i = 0; i < 8; i++) drive(1'b1, 32'h1000 + 32'(4 * i), 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 32'h2000 + 32'(4 * i), 1'b1, 1'b0);
            check("t3_count8", fq_count, 4'd8);
            check("t3_no_ovf", fq_overflow, 1'b0);
            if (i == 0) check("t3_head", deq_pc, 32'h1004);
        end
        for (int i = 0; i < 4; i++) drive(1'b0, '0, 1'b1, 1'b0);
        check("t3_wrap_head", deq_pc, 32'h2000);
        for (int i = 0; i < 4; i++) drive(1'b0, '0, 1'b1, 1'b0);
        check("t3_drained", fq_count, 4'd0);

        // 4. flush with enq and deq in the same cycle
        for (int i = 0; i < 5; i++) drive(1'b1, 32'h300 + 32'(4 * i), 1'b0, 1'b0);
        drive(1'b1, 32'hDEAD0, 1'b1, 1'b1);
        check("t4_count0", fq_count, 4'd0);
        check("t4_valid0", deq_valid, 1'b0);
        drive(1'b1, 32'h200, 1'b0, 1'b0);
        check("t4_post_redirect", deq_pc, 32'h200);
        check("t4_count1", fq_count, 4'd1);
        drive(1'b0, '0, 1'b1, 1'b0);

        // 5. overflow survives flush; reset mid-push clears everything
        for (int i = 0; i < 9; i++) drive(1'b1, 32'h400 + 32'(4 * i), 1'b0, 1'b0);
        check("t5_ovf_set", fq_overflow, 1'b1);
        drive(1'b0, '0, 1'b0, 1'b1);
        check("t5_ovf_kept", fq_overflow, 1'b1);
        for (int i = 0; i < 4; i++) drive(1'b1, 32'h600 + 32'(4 * i), 1'b0, 1'b0);
        check("t5_count4", fq_count, 4'd4);
        step(1'b1, 32'h700, 32'h7, 1'b1, 14'h7, 1'b1, 1'b0, 1'b1);
        check("t5_rst_count", fq_count, 4'd0);
        check("t5_rst_ovf", fq_overflow, 1'b0);
        drive(1'b1, 32'h100, 1'b0, 1'b0);
        check("t5_head", deq_pc, 32'h100);

        // 6. randomized traffic, alternating fill-heavy and drain-heavy phases
        for (int i = 0; i < 10000; i++) begin
            bit fill_phase;
            fill_phase = ((i / 256) % 2) == 0;
            step($urandom_range(0, 99) < (fill_phase ? 80 : 40),
                 $urandom(), $urandom(), 1'($urandom()), 14'($urandom()),
                 $urandom_range(0, 99) < (fill_phase ? 40 : 80),
                 $urandom_range(0, 99) == 0,
                 $urandom_range(0, 999) == 0);
        end
        drive(1'b0, '0, 1'b0, 1'b0);
        @(negedge clk);
        chk_en = 1'b0;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
